spi_multi_lane_master: RTL and testbench
========================================

// Module: spi_multi_lane_master
// PURPOSE
//  Synthesizable SPI master that drives the pin-level SPI interface signals: sclk, cs, mosi0..3, miso0..3.
//  - Generalises single-lane SPI to single/dual/quad lanes, runtime CPOL/CPHA, parametrised slave count and word width.
//  - Sits between a register/sequencer front end (start/ready handshake) and the SPI pins in hdlTop.
// PARAMETERS
//  NO_OF_SLAVES   1   number of active-low chip selects
//  DATA_WIDTH     8   bits per transfer; must be a multiple of 4
//  CLK_DIV_WIDTH  8   width of clk_div; sclk half-period = clk_div+1 pclk cycles
// PORTS
//  pclk       in   1                  system clock, all logic on posedge
//  areset     in   1                  asynchronous active-low reset
//  start      in   1                  transfer request, accepted when start && ready
//  ready      out  1                  high in IDLE only
//  tx_data    in   DATA_WIDTH         word to transmit, MSB first
//  slave_sel  in   $clog2(NO_OF_SLAVES)+1  index of cs bit to assert
//  lanes      in   2                  00 single, 01 dual, 10 quad, 11 reserved
//  cpol       in   1                  sclk idle level
//  cpha       in   1                  0: sample leading edge; 1: sample trailing edge
//  clk_div    in   CLK_DIV_WIDTH      sclk half-period minus one
//  rx_data    out  DATA_WIDTH         received word, valid with rx_valid, held until next capture
//  rx_valid   out  1                  one-cycle pulse at transfer end
//  busy       out  1                  ~ready
//  sclk       out  1                  SPI clock
//  cs         out  NO_OF_SLAVES       active-low chip selects
//  mosi0..3   out  1 each             master-out lanes
//  miso0..3   in   1 each             master-in lanes
// BEHAVIOUR
//  Reset (areset=0, immediate, also mid-transfer): FSM=IDLE, ready=1, busy=0, sclk=0, cs='1, mosi*=0, rx_data=0, rx_valid=0.
//  Accept rule:
//   - start is accepted only when ready=1, slave_sel<NO_OF_SLAVES and lanes!=11.
//   - Otherwise start is ignored and ready stays 1.
//  Latching: tx_data, slave_sel, lanes, cpol, cpha and clk_div are latched on accept; input changes afterwards have no effect.
//  IDLE: sclk registered from the cpol input each cycle; cs='1.
//  Lanes per edge: L = 1/2/4; beats N = DATA_WIDTH/L.
//   - Quad: beat bits map to mosi3..mosi0, MSB of the nibble on mosi3.
//   - Dual: mosi1/mosi0. Single: mosi0.
//   - Unused mosi lanes are driven 0; unused miso lanes are ignored.
//  FSM states:
//   - IDLE -> SETUP on accept (cycle 0). The cs[slave_sel] low is registered at cycle 1.
//     If cpha=0, the first beat is driven on mosi in SETUP.
//   - SETUP: one half-period with sclk=cpol, then -> SHIFT.
//   - SHIFT: 2N half-periods; sclk toggles at each half-period boundary.
//     - cpha=0: sample miso on leading edges; drive the next beat on trailing edges.
//     - cpha=1: drive on leading edges; sample on trailing edges.
//     - Received beats are shifted in MSB first.
//     - After the 2N-th half-period, sclk=cpol -> HOLD.
//   - HOLD: one half-period with cs still low. Then cs='1, rx_valid=1 for one cycle, rx_data updated, -> IDLE.
//  Latency: rx_valid asserts exactly 1+(clk_div+1)*(2N+2) pclk cycles after the accept cycle.
//  A new start in the rx_valid cycle is legal and accepted (back-to-back); cs deasserts for at least 1 pclk between transfers.
//  clk_div=0 is legal: sclk = pclk/2.
//  Half-period counter width is CLK_DIV_WIDTH; beat counter width is $clog2(DATA_WIDTH)+1. No wrap occurs within a transfer.
// CONFIGURATION
//  SPI_LOOPBACK_EN defined:
//   - Adds input port loopback (1 bit), latched on accept.
//   - When latched 1, sampled data is taken from the internal mosi lane values instead of miso; pins are still driven normally.
//  SPI_LOOPBACK_EN undefined: port absent; miso is always sampled.
// TESTING
//  Reset mid-SHIFT: assert areset low -> same cycle sclk=0, cs='1, ready=1, and no rx_valid afterwards.
//  Single, mode 0:
//   - Stimulus: DATA_WIDTH=8, clk_div=1, tx_data=8'hA5, miso driven with 8'h3C.
//   - Response: mosi0 bit sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid at cycle 37; 8 sclk pulses.
//  Quad, mode 3:
//   - Stimulus: tx_data=8'hC3, cpol=1, cpha=1, clk_div=0, miso3..0 = 4'h9 then 4'h6.
//   - Response: mosi3..0 = 4'hC then 4'h3; rx_data=8'h96; sclk idles at 1; rx_valid at cycle 7.
//  Dual, NO_OF_SLAVES=4, slave_sel=2: cs=4'b1011 during transfer only; 4 sclk pulses; mosi2/mosi3 stay 0.
//  Protocol checks:
//   - start with slave_sel=4 or lanes=11: ignored; cs stays '1, ready stays 1.
//   - start while busy: ignored.
//   - back-to-back start in the rx_valid cycle: accepted.
//  SPI_LOOPBACK_EN, loopback=1, tx_data=8'h5A, miso tied 0: rx_data=8'h5A in every lane mode.

Source files
------------

// File: rtl/spi_multi_lane_master_if.sv
// rtl/spi_multi_lane_master_if.sv - front-end handshake and SPI pin bundle for spi_multi_lane_master
interface spi_multi_lane_master_if #(
    parameter int NO_OF_SLAVES  = 1,
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_DIV_WIDTH = 8
);
    localparam int SEL_W = $clog2(NO_OF_SLAVES) + 1;

    logic                     start;
    logic                     ready;
    logic                     busy;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic [SEL_W-1:0]         slave_sel;
    logic [1:0]               lanes;
    logic                     cpol;
    logic                     cpha;
    logic [CLK_DIV_WIDTH-1:0] clk_div;
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     rx_valid;
    logic                     sclk;
    logic [NO_OF_SLAVES-1:0]  cs;
    logic                     mosi0, mosi1, mosi2, mosi3;
    logic                     miso0, miso1, miso2, miso3;
`ifdef SPI_LOOPBACK_EN
    logic                     loopback;
`endif

    modport master (
`ifdef SPI_LOOPBACK_EN
        input  loopback,
`endif
        input  start, tx_data, slave_sel, lanes, cpol, cpha, clk_div,
        input  miso0, miso1, miso2, miso3,
        output ready, busy, rx_data, rx_valid, sclk, cs,
        output mosi0, mosi1, mosi2, mosi3
    );

    modport slave (
`ifdef SPI_LOOPBACK_EN
        output loopback,
`endif
        output start, tx_data, slave_sel, lanes, cpol, cpha, clk_div,
        output miso0, miso1, miso2, miso3,
        input  ready, busy, rx_data, rx_valid, sclk, cs,
        input  mosi0, mosi1, mosi2, mosi3
    );
endinterface

// File: rtl/spi_multi_lane_master.sv
// rtl/spi_multi_lane_master.sv - single/dual/quad lane SPI master, runtime CPOL/CPHA (optional SPI_LOOPBACK_EN)
module spi_multi_lane_master #(
    parameter int NO_OF_SLAVES  = 1,
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_DIV_WIDTH = 8
) (
    input  logic                    pclk,
    input  logic                    areset,
    spi_multi_lane_master_if.master bus
);
    localparam int SEL_W  = $clog2(NO_OF_SLAVES) + 1;
    localparam int BEAT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(NO_OF_SLAVES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                   state_q, state_d;
    logic [CLK_DIV_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     phase_q, phase_d;
    logic [1:0]               lanes_q, lanes_d;
    logic                     cpol_q, cpol_d;
    logic                     cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0]    tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0]    rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     sclk_q, sclk_d;
    logic [NO_OF_SLAVES-1:0]  cs_q, cs_d;
    logic [3:0]               mosi_q, mosi_d;
`ifdef SPI_LOOPBACK_EN
    logic                     lb_q, lb_d;
`endif

    logic       accept;
    logic       boundary;
    logic       do_sample;
    logic       do_drive;
    logic [3:0] sample_src;

    // Beat presented on the mosi lanes: MSB of the beat on the highest used lane.
    function automatic logic [3:0] head_beat(input logic [1:0] ln, input logic [DATA_WIDTH-1:0] d);
        case (ln)
            2'b01:   head_beat = {2'b00, d[DATA_WIDTH-1 -: 2]};
            2'b10:   head_beat = d[DATA_WIDTH-1 -: 4];
            default: head_beat = {3'b000, d[DATA_WIDTH-1]};
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [1:0] ln, input logic [DATA_WIDTH-1:0] d);
        case (ln)
            2'b01:   shift_tx = d << 2;
            2'b10:   shift_tx = d << 4;
            default: shift_tx = d << 1;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [1:0] ln, input logic [DATA_WIDTH-1:0] d,
                                                       input logic [3:0] s);
        case (ln)
            2'b01:   shift_rx = {d[DATA_WIDTH-3:0], s[1:0]};
            2'b10:   shift_rx = {d[DATA_WIDTH-5:0], s};
            default: shift_rx = {d[DATA_WIDTH-2:0], s[0]};
        endcase
    endfunction

    function automatic logic [BEAT_W-1:0] last_beat(input logic [1:0] ln);
        case (ln)
            2'b01:   last_beat = BEAT_W'(DATA_WIDTH / 2 - 1);
            2'b10:   last_beat = BEAT_W'(DATA_WIDTH / 4 - 1);
            default: last_beat = BEAT_W'(DATA_WIDTH - 1);
        endcase
    endfunction

    assign accept   = bus.start && (state_q == S_IDLE) && (bus.slave_sel < SEL_LIMIT) && (bus.lanes != 2'b11);
    assign boundary = (hcnt_q == '0);

    // Sample source: miso pins, or the lanes we are driving when loopback was latched.
    always_comb begin
        sample_src = {bus.miso3, bus.miso2, bus.miso1, bus.miso0};
`ifdef SPI_LOOPBACK_EN
        if (lb_q) begin
            sample_src = mosi_q;
        end
`endif
    end

    // Next-state and datapath: half-period timer drives SETUP/SHIFT/HOLD sequencing.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        div_d      = div_q;
        beat_d     = beat_q;
        phase_d    = phase_q;
        lanes_d    = lanes_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
`ifdef SPI_LOOPBACK_EN
        lb_d       = lb_q;
`endif
        do_sample  = 1'b0;
        do_drive   = 1'b0;

        if (state_q != S_IDLE) begin
            hcnt_d = boundary ? div_q : hcnt_q - CLK_DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                sclk_d = bus.cpol;
                cs_d   = '1;
                mosi_d = 4'b0000;
                if (accept) begin
                    state_d = S_SETUP;
                    hcnt_d  = bus.clk_div;
                    div_d   = bus.clk_div;
                    lanes_d = bus.lanes;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    rx_sr_d = '0;
                    cs_d    = ~(NO_OF_SLAVES'(1) << bus.slave_sel);
`ifdef SPI_LOOPBACK_EN
                    lb_d    = bus.loopback;
`endif
                    // Mode with cpha=0 needs the first beat on the pins before the first edge.
                    if (!bus.cpha) begin
                        mosi_d  = head_beat(bus.lanes, bus.tx_data);
                        tx_sr_d = shift_tx(bus.lanes, bus.tx_data);
                    end else begin
                        tx_sr_d = bus.tx_data;
                    end
                end
            end
            S_SETUP: begin
                if (boundary) begin
                    state_d   = S_SHIFT;
                    sclk_d    = ~sclk_q;
                    beat_d    = '0;
                    phase_d   = 1'b0;
                    do_sample = !cpha_q;
                    do_drive  = cpha_q;
                end
            end
            S_SHIFT: begin
                if (boundary) begin
                    if (!phase_q) begin
                        // Trailing edge of the current pulse.
                        sclk_d    = ~sclk_q;
                        phase_d   = 1'b1;
                        do_sample = cpha_q;
                        do_drive  = !cpha_q && (beat_q != last_beat(lanes_q));
                    end else if (beat_q == last_beat(lanes_q)) begin
                        state_d = S_HOLD;
                    end else begin
                        // Leading edge of the next pulse.
                        sclk_d    = ~sclk_q;
                        beat_d    = beat_q + BEAT_W'(1);
                        phase_d   = 1'b0;
                        do_sample = !cpha_q;
                        do_drive  = cpha_q;
                    end
                end
            end
            S_HOLD: begin
                if (boundary) begin
                    state_d    = S_IDLE;
                    cs_d       = '1;
                    sclk_d     = cpol_q;
                    mosi_d     = 4'b0000;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_sample) begin
            rx_sr_d = shift_rx(lanes_q, rx_sr_q, sample_src);
        end
        if (do_drive) begin
            mosi_d  = head_beat(lanes_q, tx_sr_q);
            tx_sr_d = shift_tx(lanes_q, tx_sr_q);
        end
    end

    // State and datapath registers; reset forces pins idle immediately.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_IDLE;
            hcnt_q     <= '0;
            div_q      <= '0;
            beat_q     <= '0;
            phase_q    <= 1'b0;
            lanes_q    <= 2'b00;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= '1;
            mosi_q     <= 4'b0000;
`ifdef SPI_LOOPBACK_EN
            lb_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            div_q      <= div_d;
            beat_q     <= beat_d;
            phase_q    <= phase_d;
            lanes_q    <= lanes_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
`ifdef SPI_LOOPBACK_EN
            lb_q       <= lb_d;
`endif
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.sclk     = sclk_q;
    assign bus.cs       = cs_q;
    assign bus.mosi0    = mosi_q[0];
    assign bus.mosi1    = mosi_q[1];
    assign bus.mosi2    = mosi_q[2];
    assign bus.mosi3    = mosi_q[3];
endmodule

// File: tb/tb_spi_multi_lane_master.sv
// tb/tb_spi_multi_lane_master.sv - directed bench for spi_multi_lane_master with a behavioural SPI slave
module tb_spi_multi_lane_master;
    logic pclk = 1'b0;
    logic areset = 1'b0;
    always #5 pclk = ~pclk;

    spi_multi_lane_master_if #(.NO_OF_SLAVES(4), .DATA_WIDTH(8), .CLK_DIV_WIDTH(8)) bus ();

    spi_multi_lane_master #(.NO_OF_SLAVES(4), .DATA_WIDTH(8), .CLK_DIV_WIDTH(8)) dut (
        .pclk   (pclk),
        .areset (areset),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Behavioural slave state
    logic [7:0] miso_word = 8'h00;
    logic [7:0] slv_sr = 8'h00;
    logic [7:0] cap = 8'h00;
    logic [3:0] unused_or = 4'h0;
    logic [3:0] cs_seen = 4'hF;
    logic       slv_active = 1'b0;
    logic       slv_prev = 1'b0;
    logic       tr_cpol = 1'b0;
    logic       tr_cpha = 1'b0;
    logic [1:0] tr_lanes = 2'b00;
    logic       miso_zero = 1'b0;
    int         pulses = 0;

    function automatic int lane_n(input logic [1:0] ln);
        return (ln == 2'b10) ? 4 : (ln == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] ln);
        return (ln == 2'b10) ? 4'hF : (ln == 2'b01) ? 4'h3 : 4'h1;
    endfunction

    // Unused miso lanes are driven high so the master must ignore them.
    task automatic present();
        int l;
        logic [3:0] v;
        l = lane_n(tr_lanes);
        v = 4'hF;
        for (int i = 0; i < l; i++) v[i] = slv_sr[8 - l + i];
        slv_sr = slv_sr << l;
        if (miso_zero) v = 4'h0;
        bus.miso0 = v[0];
        bus.miso1 = v[1];
        bus.miso2 = v[2];
        bus.miso3 = v[3];
    endtask

    task automatic capture();
        logic [3:0] m;
        m = {bus.mosi3, bus.mosi2, bus.mosi1, bus.mosi0};
        for (int i = lane_n(tr_lanes) - 1; i >= 0; i--) cap = {cap[6:0], m[i]};
    endtask

    always begin
        @(posedge pclk);
        #1;
        if (bus.cs == 4'hF) begin
            slv_active = 1'b0;
        end else if (!slv_active) begin
            slv_active = 1'b1;
            slv_sr     = miso_word;
            slv_prev   = bus.sclk;
            cap        = 8'h00;
            pulses     = 0;
            unused_or  = 4'h0;
            cs_seen    = bus.cs;
            if (!tr_cpha) present();
        end else if (bus.sclk != slv_prev) begin
            slv_prev = bus.sclk;
            if (bus.sclk != tr_cpol) pulses++;
            if ((bus.sclk != tr_cpol) != tr_cpha) capture();
            else present();
        end
        if (slv_active)
            unused_or = unused_or | ({bus.mosi3, bus.mosi2, bus.mosi1, bus.mosi0} & ~lane_mask(tr_lanes));
    end

    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] mw, input logic [2:0] sel,
                        input logic [1:0] ln, input logic pol, input logic pha, input logic [7:0] div,
                        input int exp_lat, input logic [7:0] exp_rx, input logic [3:0] exp_cs,
                        input int exp_pulses);
        int n;
        @(negedge pclk);
        tr_cpol = pol; tr_cpha = pha; tr_lanes = ln; miso_word = mw;
        bus.tx_data = tx; bus.slave_sel = sel; bus.lanes = ln;
        bus.cpol = pol; bus.cpha = pha; bus.clk_div = div; bus.start = 1'b1;
        check({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
        @(posedge pclk);
        #1;
        n = 1;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        // Scramble every input; the latched copies must carry the transfer. start stays high while busy.
        bus.tx_data = ~tx; bus.slave_sel = sel ^ 3'd1; bus.lanes = ln ^ 2'b11;
        bus.cpol = ~pol; bus.cpha = ~pha; bus.clk_div = div + 8'd3;
        while (n < 300) begin
            if (n == 3) begin
                bus.start = 1'b0;
                bus.cpol  = pol;
            end
            @(posedge pclk);
            #1;
            n++;
            if (bus.rx_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(exp_rx));
        check({tag, "_mosi_bits"}, 32'(cap), 32'(tx));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        check({tag, "_cs_active"}, 32'(cs_seen), 32'(exp_cs));
        check({tag, "_unused_mosi"}, 32'(unused_or), 32'd0);
        check({tag, "_cs_end"}, 32'(bus.cs), 32'hF);
        check({tag, "_sclk_end"}, 32'(bus.sclk), 32'(pol));
        check({tag, "_ready_end"}, 32'(bus.ready), 32'd1);
    endtask

    task automatic idle_check(input string tag, input int cycles, input logic pol);
        for (int k = 0; k < cycles; k++) begin
            @(posedge pclk);
            #1;
            check({tag, "_cs"}, 32'(bus.cs), 32'hF);
            check({tag, "_ready"}, 32'(bus.ready), 32'd1);
            check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
            check({tag, "_sclk"}, 32'(bus.sclk), 32'(pol));
        end
    endtask

    initial begin
        int hits;
        int cs_bad;
        bus.start = 1'b0; bus.tx_data = 8'h00; bus.slave_sel = 3'd0; bus.lanes = 2'b00;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd0;
        bus.miso0 = 1'b0; bus.miso1 = 1'b0; bus.miso2 = 1'b0; bus.miso3 = 1'b0;
`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        repeat (3) @(posedge pclk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_cs", 32'(bus.cs), 32'hF);
        check("rst_mosi", 32'({bus.mosi3, bus.mosi2, bus.mosi1, bus.mosi0}), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        @(negedge pclk);
        areset = 1'b1;

        // Illegal requests: out-of-range select, reserved lane code.
        @(negedge pclk);
        bus.slave_sel = 3'd4; bus.lanes = 2'b00; bus.start = 1'b1;
        idle_check("bad_sel", 4, 1'b0);
        @(negedge pclk);
        bus.slave_sel = 3'd0; bus.lanes = 2'b11;
        idle_check("bad_lanes", 4, 1'b0);
        @(negedge pclk);
        bus.start = 1'b0; bus.lanes = 2'b00;

        // Single mode 0, then quad mode 3 started in the rx_valid cycle.
        xfer("single_m0", 8'hA5, 8'h3C, 3'd0, 2'b00, 1'b0, 1'b0, 8'd1, 37, 8'h3C, 4'b1110, 8);
        xfer("quad_m3",   8'hC3, 8'h96, 3'd1, 2'b10, 1'b1, 1'b1, 8'd0,  7, 8'h96, 4'b1101, 2);
        idle_check("idle_after_quad", 3, 1'b1);
        xfer("dual_m1",   8'h6E, 8'hB1, 3'd2, 2'b01, 1'b0, 1'b1, 8'd2, 31, 8'hB1, 4'b1011, 4);
        xfer("single_m2", 8'h81, 8'h7E, 3'd3, 2'b00, 1'b1, 1'b0, 8'd0, 19, 8'h7E, 4'b0111, 8);
        idle_check("idle_after_single", 3, 1'b1);

        // Reset in the middle of SHIFT.
        @(negedge pclk);
        tr_cpol = 1'b1; tr_cpha = 1'b0; tr_lanes = 2'b00; miso_word = 8'hFF;
        bus.tx_data = 8'hFF; bus.slave_sel = 3'd0; bus.lanes = 2'b00;
        bus.cpol = 1'b1; bus.cpha = 1'b0; bus.clk_div = 8'd1; bus.start = 1'b1;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge pclk);
        @(negedge pclk);
        areset = 1'b0;
        #1;
        check("midrst_sclk", 32'(bus.sclk), 32'd0);
        check("midrst_cs", 32'(bus.cs), 32'hF);
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        @(negedge pclk);
        areset = 1'b1;
        hits = 0;
        cs_bad = 0;
        repeat (50) begin
            @(posedge pclk);
            #1;
            if (bus.rx_valid) hits++;
            if (bus.cs != 4'hF) cs_bad++;
        end
        check("midrst_no_rx_valid", 32'(hits), 32'd0);
        check("midrst_cs_idle", 32'(cs_bad), 32'd0);

`ifdef SPI_LOOPBACK_EN
        @(negedge pclk);
        bus.loopback = 1'b1;
        miso_zero = 1'b1;
        xfer("lb_single", 8'h5A, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 8'd0, 19, 8'h5A, 4'b1110, 8);
        xfer("lb_dual",   8'h5A, 8'h00, 3'd0, 2'b01, 1'b0, 1'b0, 8'd0, 11, 8'h5A, 4'b1110, 4);
        xfer("lb_quad",   8'h5A, 8'h00, 3'd0, 2'b10, 1'b0, 1'b0, 8'd0,  7, 8'h5A, 4'b1110, 2);
        miso_zero = 1'b0;
        bus.loopback = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
